// File: rtl/mult_lp_accum.sv
// Aligns multiplier products with a LAT-deep valid/last tag line and sums them per frame.
// Frame sum registered LAT+1 cycles after last operand; a held, unaccepted result drops new ones (drop_err).
module mult_lp_accum #(
    parameter int W   = 16,
    parameter int G   = 4,
    parameter int LAT = W + 2,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              op_last,
    input  logic [2*W-1:0]    prod,
    output logic [2*W+G-1:0]  sum_data,
    output logic [CW-1:0]     sum_terms,
    output logic              sum_ovf,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy,
    output logic              drop_err,
    input  logic              clr_err
);
    localparam int AW = 2*W + G;

    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_l;
    logic           tap_v;
    logic           tap_l;

    logic [AW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic           ovf;
    logic           empty;

    logic [AW-1:0]  base;
    logic [AW:0]    add_res;
    logic [AW-1:0]  nxt_acc;
    logic [CW-1:0]  nxt_cnt;
    logic           nxt_ovf;
    logic           complete;
    logic           out_free;

    // Tag line mirrors the multiplier pipeline; it never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_l <= '0;
        end else begin
            tag_v[0] <= op_valid;
            tag_l[0] <= op_valid & op_last;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    assign tap_v = tag_v[LAT-1];
    assign tap_l = tag_l[LAT-1];

    // An empty accumulator starts the frame from zero, so first term loads prod directly.
    always_comb begin
        base    = empty ? '0 : acc;
        add_res = {1'b0, base} + {{(G+1){1'b0}}, prod};
        nxt_acc = add_res[AW-1:0];
        nxt_ovf = (~empty & ovf) | add_res[AW];
        if (empty)
            nxt_cnt = CW'(1);
        else if (&cnt)
            nxt_cnt = cnt;
        else
            nxt_cnt = cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            empty <= 1'b1;
        end else if (tap_v) begin
            acc   <= nxt_acc;
            cnt   <= nxt_cnt;
            ovf   <= nxt_ovf;
            empty <= tap_l;
        end
    end

    assign complete = tap_v & tap_l;
    assign out_free = ~sum_valid | sum_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid <= 1'b0;
            sum_data  <= '0;
            sum_terms <= '0;
            sum_ovf   <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (complete && out_free) begin
                sum_valid <= 1'b1;
                sum_data  <= nxt_acc;
                sum_terms <= nxt_cnt;
                sum_ovf   <= nxt_ovf;
            end else if (sum_valid && sum_ready) begin
                sum_valid <= 1'b0;
            end
            // A lost frame outranks a same-cycle clear.
            if (complete && !out_free)
                drop_err <= 1'b1;
            else if (clr_err)
                drop_err <= 1'b0;
        end
    end

    assign busy = (|tag_v) | (|tag_l) | ~empty;

endmodule

// File: tb/tb_mult_lp_accum.sv
module tb_mult_lp_accum;
    localparam int W   = 16;
    localparam int LAT = W + 2;
    localparam int CW  = 16;
    localparam int AW  = 2*W + 4;
    localparam int AW0 = 2*W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           op_valid, op_last, sum_ready, clr_err;
    logic [W-1:0]   opa, opb;
    logic [2*W-1:0] mpipe [0:LAT-1];
    logic [2*W-1:0] prod;

    logic [AW-1:0]  sum_data;
    logic [CW-1:0]  sum_terms;
    logic           sum_ovf, sum_valid, busy, drop_err;

    logic [AW0-1:0] s0_data;
    logic [CW-1:0]  s0_terms;
    logic           s0_ovf, s0_valid, s0_busy, s0_drop;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] got_d[$], got_t[$], got_o[$];
    logic [63:0] exp_d[$], exp_t[$], exp_o[$];

    // Behavioural stand-in for the pipelined multiplier: product appears LAT cycles later.
    always_ff @(posedge clk) begin
        mpipe[0] <= opa * opb;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign prod = mpipe[LAT-1];

    mult_lp_accum #(.W(W), .G(4), .LAT(LAT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_last(op_last), .prod(prod),
        .sum_data(sum_data), .sum_terms(sum_terms), .sum_ovf(sum_ovf), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .busy(busy), .drop_err(drop_err), .clr_err(clr_err)
    );

    mult_lp_accum #(.W(W), .G(0), .LAT(LAT), .CW(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_last(op_last), .prod(prod),
        .sum_data(s0_data), .sum_terms(s0_terms), .sum_ovf(s0_ovf), .sum_valid(s0_valid),
        .sum_ready(sum_ready), .busy(s0_busy), .drop_err(s0_drop), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; record a beat if the main DUT handshakes on this edge.
    task automatic tick();
        logic x;
        logic [63:0] d, t, o;
        x = sum_valid && sum_ready;
        d = 64'(sum_data);
        t = 64'(sum_terms);
        o = 64'(sum_ovf);
        @(posedge clk);
        #1;
        if (x) begin
            got_d.push_back(d);
            got_t.push_back(t);
            got_o.push_back(o);
        end
    endtask

    task automatic term(input logic [W-1:0] a, input logic [W-1:0] b, input logic v, input logic l);
        opa = a; opb = b; op_valid = v; op_last = l;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) term(W'($urandom), W'($urandom), 1'b0, 1'($urandom));
    endtask

    task automatic clear_got();
        got_d.delete(); got_t.delete(); got_o.delete();
    endtask

    initial begin
        int vcount;
        longint unsigned total;
        int nterms;

        rst_n = 1'b0; op_valid = 1'b0; op_last = 1'b0; sum_ready = 1'b1; clr_err = 1'b0;
        opa = '0; opb = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", 64'(sum_valid), 0);
        chk("rst_data",  64'(sum_data),  0);
        chk("rst_terms", 64'(sum_terms), 0);
        chk("rst_ovf",   64'(sum_ovf),   0);
        chk("rst_busy",  64'(busy),      0);
        chk("rst_drop",  64'(drop_err),  0);

        // Single frame: 3*5 + 7*11 + 2*100 = 292, visible LAT+1 cycles after last operand
        clear_got();
        term(3, 5, 1, 0);
        chk("sf_busy", 64'(busy), 1);
        term(7, 11, 1, 0);
        term(2, 100, 1, 1);
        idle(LAT - 1);
        chk("sf_early", 64'(sum_valid), 0);
        idle(1);
        chk("sf_valid", 64'(sum_valid), 1);
        chk("sf_data",  64'(sum_data),  292);
        chk("sf_terms", 64'(sum_terms), 3);
        chk("sf_ovf",   64'(sum_ovf),   0);
        idle(1);
        chk("sf_beats", 64'(got_d.size()), 1);
        chk("sf_drain", 64'(sum_valid), 0);
        chk("sf_idle_busy", 64'(busy), 0);

        // Overflow on the G=0 instance; guard bits absorb it on the G=4 instance
        term(16'hFFFF, 16'hFFFF, 1, 0);
        term(16'hFFFF, 16'hFFFF, 1, 1);
        idle(LAT);
        chk("ov_valid0", 64'(s0_valid), 1);
        chk("ov_data0",  64'(s0_data),  64'hFFFC_0002);
        chk("ov_ovf0",   64'(s0_ovf),   1);
        chk("ov_terms0", 64'(s0_terms), 2);
        chk("ov_data4",  64'(sum_data), 64'h1_FFFC_0002);
        chk("ov_ovf4",   64'(sum_ovf),  0);
        term(1, 1, 1, 1);
        idle(LAT);
        chk("ov_next_data0", 64'(s0_data), 1);
        chk("ov_next_ovf0",  64'(s0_ovf),  0);
        chk("ov_next_terms0", 64'(s0_terms), 1);
        idle(2);

        // Back-to-back single-term frames
        clear_got();
        for (int k = 1; k <= 4; k++) term(W'(k), W'(k), 1, 1);
        idle(LAT - 3);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("b2b_valid%0d", k), 64'(sum_valid), 1);
            chk($sformatf("b2b_data%0d", k),  64'(sum_data),  64'(k*k));
            chk($sformatf("b2b_terms%0d", k), 64'(sum_terms), 1);
            idle(1);
        end
        chk("b2b_beats", 64'(got_d.size()), 4);

        // Backpressure and drop: A=4 held, B=9 lost
        clear_got();
        sum_ready = 1'b0;
        term(2, 2, 1, 1);
        term(3, 3, 1, 1);
        idle(LAT);
        chk("bp_valid", 64'(sum_valid), 1);
        chk("bp_drop",  64'(drop_err),  1);
        chk("bp_data",  64'(sum_data),  4);
        idle(3);
        chk("bp_hold",  64'(sum_data),  4);
        sum_ready = 1'b1;
        idle(1);
        chk("bp_xfer_n", 64'(got_d.size()), 1);
        if (got_d.size() > 0) chk("bp_xfer_d", got_d[0], 4);
        chk("bp_empty", 64'(sum_valid), 0);
        chk("bp_sticky", 64'(drop_err), 1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("bp_clr", 64'(drop_err), 0);

        // Simultaneous drain of A and completion of B
        clear_got();
        sum_ready = 1'b0;
        term(2, 2, 1, 1);
        idle(LAT);
        chk("sd_held", 64'(sum_data), 4);
        term(3, 3, 1, 1);
        idle(LAT - 1);
        sum_ready = 1'b1;
        idle(1);
        chk("sd_valid", 64'(sum_valid), 1);
        chk("sd_data",  64'(sum_data),  9);
        chk("sd_drop",  64'(drop_err),  0);
        chk("sd_xfer_n", 64'(got_d.size()), 1);
        if (got_d.size() > 0) chk("sd_xfer_d", got_d[0], 4);
        idle(2);

        // Reset mid-frame with products in flight
        term(4, 4, 1, 0);
        term(5, 5, 1, 0);
        idle(2);
        rst_n = 1'b0;
        idle(1);
        chk("mr_busy",  64'(busy),      0);
        chk("mr_valid", 64'(sum_valid), 0);
        chk("mr_data",  64'(sum_data),  0);
        chk("mr_terms", 64'(sum_terms), 0);
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            idle(1);
            if (sum_valid) vcount++;
        end
        chk("mr_no_result", 64'(vcount), 0);
        chk("mr_idle_busy", 64'(busy), 0);
        term(6, 7, 1, 1);
        idle(LAT);
        chk("mr_data42", 64'(sum_data),  42);
        chk("mr_terms1", 64'(sum_terms), 1);
        chk("mr_ovf",    64'(sum_ovf),   0);
        idle(2);

        // Randomized frames against a frame-level arithmetic model
        clear_got();
        sum_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 6);
            total = 0;
            nterms = 0;
            for (int t = 0; t < len; t++) begin
                logic [W-1:0] a, b;
                a = W'($urandom);
                b = W'($urandom);
                total += longint'(a) * longint'(b);
                nterms++;
                term(a, b, 1, (t == len - 1));
                idle($urandom_range(0, 2));
            end
            exp_d.push_back(total & ((64'd1 << AW) - 1));
            exp_t.push_back(64'(nterms));
            exp_o.push_back(64'((total >> AW) != 0));
        end
        idle(LAT + 4);
        chk("rnd_beats", 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("rnd_data%0d", i),  got_d[i], exp_d[i]);
            chk($sformatf("rnd_terms%0d", i), got_t[i], exp_t[i]);
            chk($sformatf("rnd_ovf%0d", i),   got_o[i], exp_o[i]);
        end
        chk("rnd_drop", 64'(drop_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
